// File: rtl/mvu_pkg.sv
// Shared types and width helpers for the shift-accumulate MVU controller.
// Widths derive from BMAX so every file agrees on operand-index sizes.
package mvu_pkg;

    localparam int BMAX_DEF = 8;
    localparam int LW_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Precision fields must hold the value BMAX itself, hence clog2(BMAX+1).
    function automatic int pw_of(int bmax);
        return $clog2(bmax + 1);
    endfunction

    function automatic int iw_of(int bmax);
        return (bmax > 1) ? $clog2(bmax) : 1;
    endfunction

    // Significance ranges from 0 to 2*BMAX-2.
    function automatic int sw_of(int bmax);
        return $clog2(2 * bmax);
    endfunction

    // Bounds of the activation bit index for significance s.
    function automatic int sig_lo(int s, int pw);
        return (s - pw + 1 > 0) ? s - pw + 1 : 0;
    endfunction

    function automatic int sig_hi(int s, int pa);
        return (s < pa - 1) ? s : pa - 1;
    endfunction

endpackage

// File: rtl/sig_iter.sv
// Walks (significance, abit, wbit) from the most significant bit pair down,
// flagging the first pair of each significance and the final pair of a job.
module sig_iter
    import mvu_pkg::*;
#(
    parameter int BMAX = BMAX_DEF,
    localparam int PW  = pw_of(BMAX),
    localparam int IW  = iw_of(BMAX),
    localparam int SW  = sw_of(BMAX)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          init,
    input  logic          adv,
    input  logic [PW-1:0] prec_a,
    input  logic [PW-1:0] prec_w,
    output logic [IW-1:0] abit,
    output logic [IW-1:0] wbit,
    output logic          first_of_sig,
    output logic          last
);

    logic [SW-1:0] s_q, s_d;
    logic [IW-1:0] a_q, a_d;
    int            s_i, a_i, pa_i, pw_i;

    always_ff @(posedge clk) begin
        if (clr) begin
            s_q <= '0;
            a_q <= '0;
        end else begin
            s_q <= s_d;
            a_q <= a_d;
        end
    end

    always_comb begin
        s_i  = int'(s_q);
        a_i  = int'(a_q);
        pa_i = int'(prec_a);
        pw_i = int'(prec_w);
        s_d  = s_q;
        a_d  = a_q;
        // The top pair (pa-1, pw-1) is the only one at the highest significance.
        if (init) begin
            s_d = SW'(pa_i + pw_i - 2);
            a_d = IW'(pa_i - 1);
        end else if (adv) begin
            if (a_i == sig_hi(s_i, pa_i)) begin
                if (s_q != '0) begin
                    s_d = s_q - SW'(1);
                    a_d = IW'(sig_lo(s_i - 1, pw_i));
                end
            end else begin
                a_d = a_q + IW'(1);
            end
        end
    end

    assign abit         = a_q;
    assign wbit         = IW'(s_i - a_i);
    assign first_of_sig = (a_i == sig_lo(s_i, pw_i));
    assign last         = (s_q == '0) && (a_i == sig_hi(0, pa_i));

endmodule

// File: rtl/shacc_ctrl.sv
// Issue sequencer for a bit-serial shifter-accumulator: FSM, tile counter
// and strobe decode around the sig_iter bit-pair walker.
module shacc_ctrl
    import mvu_pkg::*;
#(
    parameter int BMAX = BMAX_DEF,
    parameter int LW   = LW_DEF
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic                        start,
    input  logic [pw_of(BMAX)-1:0]      prec_a,
    input  logic [pw_of(BMAX)-1:0]      prec_w,
    input  logic [LW-1:0]               len,
    input  logic                        en,
    output logic                        sa_load,
    output logic                        sa_acc,
    output logic                        sa_sh,
    output logic [iw_of(BMAX)-1:0]      abit,
    output logic [iw_of(BMAX)-1:0]      wbit,
    output logic [LW-1:0]               tile,
    output logic                        busy,
    output logic                        done
);

    localparam int PW = pw_of(BMAX);
    localparam int IW = iw_of(BMAX);

    state_t        state_q, state_d;
    logic [PW-1:0] pa_q, pa_d, pw_q, pw_d;
    logic [LW-1:0] len_q, len_d, tile_q, tile_d;
    logic          first_q, first_d;

    logic          accept, init, adv;
    logic [PW-1:0] iter_pa, iter_pw;
    logic [IW-1:0] it_abit, it_wbit;
    logic          it_first_of_sig, it_last;

    assign accept = start && (prec_a != '0) && (prec_w != '0) && (len != '0)
                    && (int'(prec_a) <= BMAX) && (int'(prec_w) <= BMAX);

    // The iterator is seeded straight from the ports on the accept cycle.
    assign iter_pa = (state_q == ST_IDLE) ? prec_a : pa_q;
    assign iter_pw = (state_q == ST_IDLE) ? prec_w : pw_q;

    sig_iter #(.BMAX(BMAX)) u_sig_iter (
        .clk          (clk),
        .clr          (clr),
        .init         (init),
        .adv          (adv),
        .prec_a       (iter_pa),
        .prec_w       (iter_pw),
        .abit         (it_abit),
        .wbit         (it_wbit),
        .first_of_sig (it_first_of_sig),
        .last         (it_last)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            pa_q    <= '0;
            pw_q    <= '0;
            len_q   <= '0;
            tile_q  <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pa_q    <= pa_d;
            pw_q    <= pw_d;
            len_q   <= len_d;
            tile_q  <= tile_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pa_d    = pa_q;
        pw_d    = pw_q;
        len_d   = len_q;
        tile_d  = tile_q;
        first_d = first_q;
        init    = 1'b0;
        adv     = 1'b0;
        sa_load = 1'b0;
        sa_acc  = 1'b0;
        sa_sh   = 1'b0;
        abit    = '0;
        wbit    = '0;
        tile    = '0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RUN;
                    pa_d    = prec_a;
                    pw_d    = prec_w;
                    len_d   = len;
                    tile_d  = '0;
                    first_d = 1'b1;
                    init    = 1'b1;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                abit = it_abit;
                wbit = it_wbit;
                tile = tile_q;
                if (en) begin
                    sa_load = first_q;
                    sa_acc  = !first_q;
                    // Shift only when a new significance starts, before its first add.
                    sa_sh   = !first_q && it_first_of_sig && (tile_q == '0);
                    first_d = 1'b0;
                    if (tile_q == len_q - LW'(1)) begin
                        tile_d = '0;
                        adv    = 1'b1;
                        if (it_last) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        tile_d = tile_q + LW'(1);
                    end
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shacc_ctrl.sv
// Self-checking bench for shacc_ctrl: expected issues are queued per job and
// popped as the DUT issues them.
module tb_shacc_ctrl;

    localparam int BMAX = 8;
    localparam int LW   = 8;
    localparam int PW   = 4;
    localparam int IW   = 3;

    logic          clk = 1'b0;
    logic          clr;
    logic          start;
    logic [PW-1:0] prec_a;
    logic [PW-1:0] prec_w;
    logic [LW-1:0] len;
    logic          en;
    logic          sa_load;
    logic          sa_acc;
    logic          sa_sh;
    logic [IW-1:0] abit;
    logic [IW-1:0] wbit;
    logic [LW-1:0] tile;
    logic          busy;
    logic          done;

    typedef struct packed {
        logic          load;
        logic          acc;
        logic          sh;
        logic [IW-1:0] abit;
        logic [IW-1:0] wbit;
        logic [LW-1:0] tile;
    } issue_t;

    issue_t sb[$];
    int     checks   = 0;
    int     failures = 0;

    shacc_ctrl #(.BMAX(BMAX), .LW(LW)) dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .prec_a  (prec_a),
        .prec_w  (prec_w),
        .len     (len),
        .en      (en),
        .sa_load (sa_load),
        .sa_acc  (sa_acc),
        .sa_sh   (sa_sh),
        .abit    (abit),
        .wbit    (wbit),
        .tile    (tile),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic pushIssue(input logic ld, input logic ac, input logic sh,
                             input int a, input int w, input int t);
        issue_t e;
        e.load = ld;
        e.acc  = ac;
        e.sh   = sh;
        e.abit = IW'(a);
        e.wbit = IW'(w);
        e.tile = LW'(t);
        sb.push_back(e);
    endtask

    // Reference order: significance descending, abit ascending, tiles innermost.
    task automatic pushModel(input int pa, input int pw, input int ln);
        bit first;
        int lo;
        int hi;
        first = 1'b1;
        for (int s = pa + pw - 2; s >= 0; s--) begin
            lo = (s - pw + 1 > 0) ? s - pw + 1 : 0;
            hi = (s < pa - 1) ? s : pa - 1;
            for (int a = lo; a <= hi; a++) begin
                for (int t = 0; t < ln; t++) begin
                    pushIssue(first, !first, !first && (a == lo) && (t == 0), a, s - a, t);
                    first = 1'b0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input int pa, input int pw, input int ln);
        @(negedge clk);
        prec_a = PW'(pa);
        prec_w = PW'(pw);
        len    = LW'(ln);
        start  = 1'b1;
        en     = 1'b1;
    endtask

    // Runs a job whose expected issues are already queued; en drops for
    // stall_n cycles starting at RUN cycle stall_at.
    task automatic runJob(input int pa, input int pw, input int ln,
                          input int stall_at, input int stall_n);
        int     cyc;
        int     exp_done;
        bit     seen_done;
        issue_t e;
        exp_done  = pa * pw * ln + stall_n + 1;
        seen_done = 1'b0;
        cyc       = 0;
        applyStimulus(pa, pw, ln);
        while (!seen_done && cyc < exp_done + 10) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            en = !(stall_n > 0 && cyc >= stall_at && cyc < stall_at + stall_n);
            #1;
            if (done) begin
                seen_done = 1'b1;
                checkOutput("done_cycle", cyc, exp_done);
                checkOutput("sb_empty_at_done", sb.size(), 0);
                checkOutput("busy_in_done", busy, 1);
                checkOutput("strobes_in_done", {sa_load, sa_acc, sa_sh, abit, wbit, tile}, 0);
            end else if (!en) begin
                checkOutput("stall_strobes", {sa_load, sa_acc, sa_sh}, 0);
                if (sb.size() > 0)
                    checkOutput("stall_indices", {abit, wbit, tile}, {sb[0].abit, sb[0].wbit, sb[0].tile});
            end else if (sb.size() == 0) begin
                checkOutput("extra_issue", {sa_load, sa_acc}, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("issue", {sa_load, sa_acc, sa_sh, abit, wbit, tile}, e);
                checkOutput("busy_in_run", busy, 1);
            end
        end
        if (!seen_done)
            checkOutput("done_timeout", seen_done, 1);
        sb.delete();
        en = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("busy_after_done", busy, 0);
        checkOutput("done_single_pulse", done, 0);
    endtask

    initial begin
        int pulses;
        clr    = 1'b1;
        start  = 1'b0;
        prec_a = '0;
        prec_w = '0;
        len    = '0;
        en     = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_outputs", {sa_load, sa_acc, sa_sh, abit, wbit, tile}, 0);

        // clr wins over a valid start in the same cycle, and nothing is queued.
        @(negedge clk);
        prec_a = 4'd2;
        prec_w = 4'd2;
        len    = 8'd1;
        start  = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("clr_priority_busy", busy, 0);
        clr   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("clr_no_queue_busy", busy, 0);

        $display("[TB] 1x1 len1");
        pushIssue(1, 0, 0, 0, 0, 0);
        runJob(1, 1, 1, 0, 0);

        $display("[TB] 2x2 len1");
        pushIssue(1, 0, 0, 1, 1, 0);
        pushIssue(0, 1, 1, 0, 1, 0);
        pushIssue(0, 1, 0, 1, 0, 0);
        pushIssue(0, 1, 1, 0, 0, 0);
        runJob(2, 2, 1, 0, 0);

        $display("[TB] 2x1 len3");
        for (int t = 0; t < 3; t++) pushIssue(t == 0, t != 0, 0, 1, 0, t);
        for (int t = 0; t < 3; t++) pushIssue(0, 1, t == 0, 0, 0, t);
        runJob(2, 1, 3, 0, 0);

        $display("[TB] 2x1 len3 with stall");
        pushModel(2, 1, 3);
        runJob(2, 1, 3, 3, 2);

        $display("[TB] 3x2 len2 and 8x8 len1");
        pushModel(3, 2, 2);
        runJob(3, 2, 2, 0, 0);
        pushModel(8, 8, 1);
        runJob(8, 8, 1, 20, 1);
        pushModel(1, 8, 2);
        runJob(1, 8, 2, 0, 0);

        $display("[TB] abort 8x8 len4 at third issue");
        applyStimulus(8, 8, 4);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            checkOutput("abort_pre_issue", {sa_load, sa_acc, tile}, {(c == 1), (c != 1), LW'(c - 1)});
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_outputs", {sa_load, sa_acc, sa_sh, abit, wbit, tile}, 0);
        pulses = 0;
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            #1;
            if (done) pulses++;
        end
        checkOutput("abort_no_done", pulses, 0);

        $display("[TB] rejected starts");
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       applyStimulus(2, 2, 0);
                1:       applyStimulus(2, BMAX + 1, 1);
                default: applyStimulus(0, 3, 2);
            endcase
            pulses = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                start = 1'b0;
                #1;
                if (busy || sa_load || sa_acc || done) pulses++;
            end
            checkOutput($sformatf("reject_%0d", k), pulses, 0);
        end

        // A good job after rejects still runs normally.
        pushModel(2, 3, 1);
        runJob(2, 3, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shacc_ctrl.md
SHACC_CTRL -- requirements
Module: shacc_ctrl

Interface
REQ-001 Parameter BMAX, default 8: maximum operand precision in bits, per operand (activation and weight).
REQ-002 Parameter LW, default 8: width of the tile-count field and the tile counter.
REQ-003 Port clk  input  1  rising-edge clock for every register in the block.
REQ-004 Port clr  input  1  reset, synchronous and active-high.
REQ-005 Port start  input  1  job request; sampled only in IDLE.
REQ-006 Port prec_a  input  clog2(BMAX+1)  activation precision, 1..BMAX; latched at start.
REQ-007 Port prec_w  input  clog2(BMAX+1)  weight precision, 1..BMAX; latched at start.
REQ-008 Port len  input  LW  tiles per bit-pair, 1..2^LW-1; latched at start.
REQ-009 Port en  input  1  operand-valid; low stalls the sequence.
REQ-010 Port sa_load  output  1  shifter-accumulator load strobe.
REQ-011 Port sa_acc  output  1  shifter-accumulator accumulate strobe.
REQ-012 Port sa_sh  output  1  shifter-accumulator shift-before-add select.
REQ-013 Port abit  output  clog2(BMAX)  activation bit-plane index of the current issue.
REQ-014 Port wbit  output  clog2(BMAX)  weight bit-plane index of the current issue.
REQ-015 Port tile  output  LW  tile index of the current issue.
REQ-016 Port busy  output  1  high from job accept through the DONE cycle.
REQ-017 Port done  output  1  one-cycle pulse; the shifter-accumulator output is final.

Function
REQ-018 States SHALL be IDLE, RUN and DONE.
REQ-019 IDLE->RUN on start=1 with prec_a, prec_w and len all nonzero and both precisions <=BMAX; any other start SHALL be ignored and the block stays IDLE.
REQ-020 In RUN, significance s SHALL iterate from prec_a+prec_w-2 down to 0.
REQ-021 Within each s, abit SHALL ascend from max(0,s-prec_w+1) to min(s,prec_a-1), with wbit=s-abit.
REQ-022 For each (abit,wbit) pair, tile SHALL iterate from 0 to len-1.
REQ-023 One issue per cycle while en=1; with en=0 all strobes SHALL be 0 and counters SHALL hold.
REQ-024 The first issue of a job SHALL assert sa_load=1, sa_acc=0, sa_sh=0.
REQ-025 The first issue of each later significance SHALL assert sa_acc=1, sa_sh=1.
REQ-026 All other issues SHALL assert sa_acc=1, sa_sh=0.
REQ-027 At most one of sa_load/sa_acc SHALL be high in any cycle.
REQ-028 Issue strobes, abit, wbit and tile SHALL be combinational from state and counters, all valid in the same cycle.
REQ-029 Total issue count SHALL equal prec_a*prec_w*len.
REQ-030 The cycle after the last issue SHALL be DONE, with done=1.
REQ-031 DONE->IDLE unconditionally.
REQ-032 start in RUN or DONE SHALL be ignored, with no queuing.
REQ-033 Outside RUN, all strobes SHALL be 0 and abit, wbit and tile SHALL be 0.

Reset
REQ-034 clr=1 SHALL force IDLE and zero all counters and latched parameters at the next edge, including mid-RUN.
REQ-035 The aborted job SHALL produce no done pulse.
REQ-036 Reset values: busy=0, done=0, all strobes 0.
REQ-037 clr SHALL take priority over start in the same cycle.

Structure
REQ-038 The state encoding and the clog2-derived widths SHALL reside in a shared package, mvu_pkg.
REQ-039 One sub-module, sig_iter, SHALL generate the (s,abit,wbit) sequence, with first_of_sig and last outputs.
REQ-040 The top level SHALL hold the FSM, the tile counter and the strobe decode.

Verification
REQ-041 prec_a=1, prec_w=1, len=1, en=1: one cycle with sa_load=1, next cycle done=1, then busy=0.
REQ-042 prec_a=2, prec_w=2, len=1: issue pairs (1,1)load, (0,1)sh, (1,0)acc, (0,0)sh; done in cycle 5.
REQ-043 prec_a=2, prec_w=1, len=3: 6 issues; sa_sh=1 only on the 4th; tile sequence 0,1,2,0,1,2.
REQ-044 Same job as REQ-043 with en=0 for 2 cycles mid-run: strobes 0 and indices held; done delayed by exactly 2 cycles.
REQ-045 clr=1 at the 3rd issue of an 8x8, len=4 job: next cycle IDLE, busy=0, no done pulse.
REQ-046 start with len=0, and separately with prec_w=BMAX+1: busy stays 0, no strobes issued.
